control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cu_pkg.sv | 44 ++++
 rtl/cu_decode.sv | 53 +++++
 rtl/control_unit.sv | 108 ++++++++++
 tb/tb_control_unit.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: FSM states, PC-select codes, opcodes and
// instruction field positions.
package cu_pkg;

  typedef enum logic [1:0] {
    StFetch,
    StExec,
    StMem,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    PcInc,
    PcBranch,
    PcImm,
    PcReg,
    PcHold
  } pc_sel_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpAlu  = 4'h1;
  localparam logic [3:0] OpAlui = 4'h2;
  localparam logic [3:0] OpLd   = 4'h3;
  localparam logic [3:0] OpSt   = 4'h4;
  localparam logic [3:0] OpBz   = 4'h5;
  localparam logic [3:0] OpBn   = 4'h6;
  localparam logic [3:0] OpJmp  = 4'h7;
  localparam logic [3:0] OpJr   = 4'h8;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam int unsigned OpMsb  = 23;
  localparam int unsigned OpLsb  = 20;
  localparam int unsigned FsMsb  = 19;
  localparam int unsigned FsLsb  = 16;
  localparam int unsigned DaMsb  = 14;
  localparam int unsigned DaLsb  = 12;
  localparam int unsigned AaMsb  = 10;
  localparam int unsigned AaLsb  = 8;
  localparam int unsigned BaMsb  = 2;
  localparam int unsigned BaLsb  = 0;
  localparam int unsigned ImmMsb = 7;
  localparam int unsigned ImmLsb = 0;

endpackage

// File: rtl/cu_decode.sv
// Combinational opcode decode: datapath strobes, PC source select and FSM hints
// for the current state.
module cu_decode
  import cu_pkg::*;
(
  input  state_e      state,
  input  logic [3:0]  op,
  input  logic        n,
  input  logic        z,
  output logic        le,
  output logic        md,
  output logic        mb,
  output logic        mw,
  output logic        is_ld,
  output logic        is_halt,
  output pc_sel_e     pc_sel
);

  always_comb begin
    le      = 1'b0;
    md      = 1'b0;
    mb      = 1'b0;
    mw      = 1'b0;
    is_ld   = 1'b0;
    is_halt = 1'b0;
    pc_sel  = PcInc;
    if (state == StExec) begin
      case (op)
        OpAlu:  le = 1'b1;
        OpAlui: begin
          le = 1'b1;
          mb = 1'b1;
        end
        // Address goes out on aa this cycle; the register write happens in MEM.
        OpLd:   is_ld = 1'b1;
        OpSt:   mw = 1'b1;
        OpBz:   if (z) pc_sel = PcBranch;
        OpBn:   if (n) pc_sel = PcBranch;
        OpJmp:  pc_sel = PcImm;
        OpJr:   pc_sel = PcReg;
        OpHalt: begin
          pc_sel  = PcHold;
          is_halt = 1'b1;
        end
        default: ;
      endcase
    end else if (state == StMem) begin
      le = 1'b1;
      md = 1'b1;
    end
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH/EXEC/MEM/HALT sequencer owning PC and IR, driving
// datapath selects and strobes decoded from the held instruction.
module control_unit
  import cu_pkg::*;
#(
  parameter int unsigned PC_W = 8,
  parameter int unsigned IW   = 24
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   imem_data,
  input  logic            N,
  input  logic            Z,
  input  logic [7:0]      Bus_A,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      AA,
  output logic [2:0]      BA,
  output logic [2:0]      DA,
  output logic [3:0]      FS,
  output logic [7:0]      CI,
  output logic            LE,
  output logic            MD,
  output logic            MB,
  output logic            MW,
  output logic            halted
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [IW-1:0]   ir_q;
  logic            halted_q;

  logic [7:0]      imm;
  logic            is_ld;
  logic            is_halt;
  logic            active;
  pc_sel_e         pc_sel;

  assign imm    = ir_q[ImmMsb:ImmLsb];
  assign active = (state_q == StExec) || (state_q == StMem);

  cu_decode u_decode (
    .state   (state_q),
    .op      (ir_q[OpMsb:OpLsb]),
    .n       (N),
    .z       (Z),
    .le      (LE),
    .md      (MD),
    .mb      (MB),
    .mw      (MW),
    .is_ld   (is_ld),
    .is_halt (is_halt),
    .pc_sel  (pc_sel)
  );

  always_comb begin
    pc_d = pc_q + PC_W'(1);
    case (pc_sel)
      PcBranch: pc_d = pc_q + PC_W'($signed(imm));
      PcImm:    pc_d = PC_W'(imm);
      PcReg:    pc_d = PC_W'(Bus_A);
      PcHold:   pc_d = pc_q;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= '0;
      ir_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          ir_q    <= imem_data;
          state_q <= StExec;
        end
        StExec: begin
          pc_q     <= pc_d;
          halted_q <= is_halt;
          if (is_ld) begin
            state_q <= StMem;
          end else if (is_halt) begin
            state_q <= StHalt;
          end else begin
            state_q <= StFetch;
          end
        end
        StMem:   state_q <= StFetch;
        default: state_q <= StHalt;
      endcase
    end
  end

  assign pc     = pc_q;
  assign halted = halted_q;
  assign AA     = active ? ir_q[AaMsb:AaLsb] : '0;
  assign BA     = active ? ir_q[BaMsb:BaLsb] : '0;
  assign DA     = active ? ir_q[DaMsb:DaLsb] : '0;
  assign FS     = active ? ir_q[FsMsb:FsLsb] : '0;
  assign CI     = active ? imm : '0;

  logic unused_ir;
  assign unused_ir = ^{ir_q[15], ir_q[11]};

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a small program in a bench-side instruction memory,
// checked cycle by cycle against hand-computed control values.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] imem_data;
  logic        N, Z;
  logic [7:0]  Bus_A;
  logic [7:0]  pc;
  logic [2:0]  AA, BA, DA;
  logic [3:0]  FS;
  logic [7:0]  CI;
  logic        LE, MD, MB, MW, halted;

  logic [23:0] mem [256];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[pc];

  control_unit #(.PC_W(8), .IW(24)) dut (
    .clk       (clk),
    .rst       (rst),
    .imem_data (imem_data),
    .N         (N),
    .Z         (Z),
    .Bus_A     (Bus_A),
    .pc        (pc),
    .AA        (AA),
    .BA        (BA),
    .DA        (DA),
    .FS        (FS),
    .CI        (CI),
    .LE        (LE),
    .MD        (MD),
    .MB        (MB),
    .MW        (MW),
    .halted    (halted)
  );

  function automatic logic [23:0] enc(input logic [3:0] op, input logic [3:0] fs,
                                      input logic [2:0] da, input logic [2:0] aa,
                                      input logic [7:0] imm);
    return {op, fs, 1'b0, da, 1'b0, aa, imm};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = enc(4'h2, 4'h2, 3'd1, 3'd0, 8'h05);  // ALUI
    mem[8'h01] = enc(4'h3, 4'h0, 3'd2, 3'd1, 8'h00);  // LD
    mem[8'h02] = enc(4'h4, 4'h0, 3'd0, 3'd3, 8'h04);  // ST
    mem[8'h03] = enc(4'h7, 4'h0, 3'd0, 3'd0, 8'h10);  // JMP 0x10
    mem[8'h10] = enc(4'h5, 4'h0, 3'd0, 3'd0, 8'hFE);  // BZ -2
    mem[8'h0E] = enc(4'h7, 4'h0, 3'd0, 3'd0, 8'h10);  // JMP 0x10
    mem[8'h11] = enc(4'h7, 4'h0, 3'd0, 3'd0, 8'hFF);  // JMP 0xFF
    mem[8'hFF] = enc(4'h0, 4'h0, 3'd0, 3'd0, 8'h00);  // NOP
    mem[8'h42] = enc(4'hF, 4'h0, 3'd0, 3'd0, 8'h00);  // HALT

    rst = 1'b1; N = 1'b0; Z = 1'b0; Bus_A = 8'h00;
    tick();
    tick();
    chk("rst_pc", pc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_le", LE, 0);
    chk("rst_mw", MW, 0);
    rst = 1'b0;

    // Cycle 1: FETCH of ALUI
    chk("fetch_le", LE, 0);
    chk("fetch_fs", FS, 0);
    chk("fetch_mb", MB, 0);
    tick();
    // Cycle 2: EXEC of ALUI
    chk("alui_le", LE, 1);
    chk("alui_mb", MB, 1);
    chk("alui_md", MD, 0);
    chk("alui_ci", CI, 8'h05);
    chk("alui_da", DA, 1);
    chk("alui_fs", FS, 2);
    tick();
    chk("alui_pc", pc, 8'h01);
    tick();
    // LD: EXEC then MEM
    chk("ld_exec_le", LE, 0);
    chk("ld_exec_mw", MW, 0);
    chk("ld_exec_aa", AA, 1);
    tick();
    chk("ld_mem_le", LE, 1);
    chk("ld_mem_md", MD, 1);
    chk("ld_mem_da", DA, 2);
    chk("ld_mem_pc", pc, 8'h02);
    tick();
    chk("ld_done_le", LE, 0);
    chk("ld_done_pc", pc, 8'h02);
    chk("st_fetch_mw", MW, 0);
    tick();
    // ST
    chk("st_mw", MW, 1);
    chk("st_le", LE, 0);
    chk("st_mb", MB, 0);
    chk("st_aa", AA, 3);
    chk("st_ba", BA, 4);
    tick();
    chk("st_after_mw", MW, 0);
    chk("st_after_le", LE, 0);
    tick();  // EXEC JMP
    tick();
    chk("jmp_pc", pc, 8'h10);
    Z = 1'b1;
    tick();  // EXEC BZ taken
    tick();
    chk("bz_taken_pc", pc, 8'h0E);
    Z = 1'b0;
    tick();  // EXEC JMP 0x10
    tick();
    chk("jmp2_pc", pc, 8'h10);
    tick();  // EXEC BZ not taken
    tick();
    chk("bz_not_pc", pc, 8'h11);
    tick();  // EXEC JMP 0xFF
    tick();
    chk("jmp_ff_pc", pc, 8'hFF);
    tick();  // EXEC NOP
    tick();
    chk("wrap_pc", pc, 8'h00);
    mem[8'h00] = enc(4'h8, 4'h0, 3'd0, 3'd5, 8'h00);  // JR r5
    Bus_A = 8'h42;
    tick();
    chk("jr_aa", AA, 5);
    tick();
    chk("jr_pc", pc, 8'h42);
    Bus_A = 8'h00;
    tick();  // EXEC HALT
    chk("halt_exec_halted", halted, 0);
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("halt_halted", halted, 1);
      chk("halt_pc", pc, 8'h42);
      chk("halt_le", LE, 0);
      chk("halt_mw", MW, 0);
      tick();
    end

    // Reset out of HALT, then interrupt a LD in MEM
    mem[8'h00] = enc(4'h3, 4'h0, 3'd2, 3'd1, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("unhalt_halted", halted, 0);
    chk("unhalt_pc", pc, 0);
    tick();  // EXEC LD
    tick();
    chk("ld2_mem_le", LE, 1);
    chk("ld2_mem_pc", pc, 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mem_pc", pc, 0);
    chk("rst_mem_le", LE, 0);
    chk("rst_mem_md", MD, 0);
    chk("rst_mem_halted", halted, 0);
    tick();
    chk("rerun_ld_exec_le", LE, 0);
    chk("rerun_ld_exec_aa", AA, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
